// File: rtl/step_rate_meter.sv
// Step-clock half-period meter: measures the spacing between transitions on the X and Y
// step lines in clk cycles, reported in divider speed encoding, with per-axis stall detection.

module step_rate_chan #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [25:0] TIMEOUT     = 26'h3FFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        step,
  output logic [25:0] speed_meas,
  output logic        valid,
  output logic        stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_r;
  logic [25:0]            count_r;
  logic [25:0]            speed_meas_r;
  logic                   valid_r;
  logic                   stalled_r;
  logic                   edge_s;

  assign edge_s     = sync_r[SYNC_STAGES-1] ^ edge_r;
  assign speed_meas = speed_meas_r;
  assign valid      = valid_r;
  assign stalled    = stalled_r;

  // Synchroniser and edge register keep running while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], step};
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Measurement FSM: an edge always beats the timeout in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= 26'd0;
      speed_meas_r <= 26'd0;
      valid_r      <= 1'b0;
      stalled_r    <= 1'b0;
    end else if (!enable) begin
      state_r   <= IDLE;
      count_r   <= 26'd0;
      valid_r   <= 1'b0;
      stalled_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          count_r <= 26'd0;
          if (edge_s) begin
            state_r <= MEASURE;
          end else begin
            state_r <= IDLE;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            speed_meas_r <= count_r;
            valid_r      <= 1'b1;
            count_r      <= 26'd0;
          end else if (count_r == TIMEOUT) begin
            valid_r   <= 1'b0;
            stalled_r <= 1'b1;
            state_r   <= STALL;
          end else begin
            valid_r <= 1'b0;
            count_r <= count_r + 26'd1;
          end
        end
        STALL: begin
          valid_r <= 1'b0;
          if (edge_s) begin
            stalled_r <= 1'b0;
            count_r   <= 26'd0;
            state_r   <= MEASURE;
          end else begin
            state_r <= STALL;
          end
        end
        default: begin
          state_r   <= IDLE;
          count_r   <= 26'd0;
          valid_r   <= 1'b0;
          stalled_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

module step_rate_meter #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [25:0] TIMEOUT     = 26'h3FFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        step_x,
  input  logic        step_y,
  output logic [25:0] speed_x_meas,
  output logic [25:0] speed_y_meas,
  output logic        valid_x,
  output logic        valid_y,
  output logic        stalled_x,
  output logic        stalled_y
);

  step_rate_chan #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_chan_x (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .step       (step_x),
    .speed_meas (speed_x_meas),
    .valid      (valid_x),
    .stalled    (stalled_x)
  );

  step_rate_chan #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_chan_y (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .step       (step_y),
    .speed_meas (speed_y_meas),
    .valid      (valid_y),
    .stalled    (stalled_y)
  );

endmodule

// File: tb/tb_step_rate_meter.sv
// Directed bench for step_rate_meter: one instance with the default timeout, one with
// TIMEOUT=50 for the stall cases; both share the same stimulus.

module tb_step_rate_meter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        step_x;
  logic        step_y;
  logic [25:0] speed_x_meas, speed_y_meas;
  logic        valid_x, valid_y, stalled_x, stalled_y;
  logic [25:0] t_speed_x, t_speed_y;
  logic        t_valid_x, t_valid_y, t_stalled_x, t_stalled_y;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  int vx_t[$], vx_v[$], vy_t[$], vy_v[$], tx_t[$], tx_v[$];
  int t_stall_rise = -1;
  bit t_stall_prev = 1'b0;
  bit rst_d = 1'b1;
  logic [25:0] prev_sx = 26'd0;
  logic [25:0] prev_sy = 26'd0;
  int bad_upd = 0;

  step_rate_meter dut (
    .clk(clk), .rst(rst), .enable(enable), .step_x(step_x), .step_y(step_y),
    .speed_x_meas(speed_x_meas), .speed_y_meas(speed_y_meas),
    .valid_x(valid_x), .valid_y(valid_y), .stalled_x(stalled_x), .stalled_y(stalled_y)
  );

  step_rate_meter #(.SYNC_STAGES(2), .TIMEOUT(26'd50)) dut_t (
    .clk(clk), .rst(rst), .enable(enable), .step_x(step_x), .step_y(step_y),
    .speed_x_meas(t_speed_x), .speed_y_meas(t_speed_y),
    .valid_x(t_valid_x), .valid_y(t_valid_y), .stalled_x(t_stalled_x), .stalled_y(t_stalled_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Log valid pulses with their cycle number and watch for silent measurement changes
  always @(negedge clk) begin
    if (valid_x) begin vx_t.push_back(cyc_n); vx_v.push_back(int'(speed_x_meas)); end
    if (valid_y) begin vy_t.push_back(cyc_n); vy_v.push_back(int'(speed_y_meas)); end
    if (t_valid_x) begin tx_t.push_back(cyc_n); tx_v.push_back(int'(t_speed_x)); end
    if (t_stalled_x && !t_stall_prev && t_stall_rise < 0) t_stall_rise = cyc_n;
    t_stall_prev = t_stalled_x;
    if (!rst_d && !rst && speed_x_meas != prev_sx && !valid_x) bad_upd++;
    if (!rst_d && !rst && speed_y_meas != prev_sy && !valid_y) bad_upd++;
    prev_sx = speed_x_meas;
    prev_sy = speed_y_meas;
    rst_d   = rst;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk_pulses(input string tag, input int qt[$], input int qv[$],
                            input int first, input int step, input int n, input int val);
    chk({tag, "_count"}, qt.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_time"}, qat(qt, i), first + i * step);
      chk({tag, "_value"}, qat(qv, i), val);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gen(input bit axis, input int half, input int n);
    for (int i = 0; i < n; i++) begin
      if (axis) step_y = ~step_y;
      else      step_x = ~step_x;
      wait_cyc(half);
    end
  endtask

  task automatic idle();
    enable = 1'b0;
    step_x = 1'b0;
    step_y = 1'b0;
    wait_cyc(5);
    vx_t.delete(); vx_v.delete(); vy_t.delete(); vy_v.delete(); tx_t.delete(); tx_v.delete();
    t_stall_rise = -1;
    enable = 1'b1;
    wait_cyc(1);
  endtask

  int t0, t1;

  initial begin
    rst = 1'b1; enable = 1'b0; step_x = 1'b0; step_y = 1'b0;
    wait_cyc(3);
    chk("rst_speed_x", speed_x_meas, 0);
    chk("rst_speed_y", speed_y_meas, 0);
    chk("rst_valid_x", valid_x, 0);
    chk("rst_valid_y", valid_y, 0);
    chk("rst_stalled_x", stalled_x, 0);
    chk("rst_stalled_y", stalled_y, 0);
    rst = 1'b0; enable = 1'b1;
    wait_cyc(2);

    // Speed 5: first edge silent, then pulses every 6 cycles, 3 cycles after each transition
    t0 = cyc_n;
    gen(1'b0, 6, 5);
    wait_cyc(4);
    chk_pulses("s5_x", vx_t, vx_v, t0 + 9, 6, 4, 5);
    chk("s5_no_y", vy_t.size(), 0);

    // Concurrent axes, independent results
    idle();
    t0 = cyc_n;
    fork
      gen(1'b0, 4, 6);
      gen(1'b1, 101, 4);
    join
    wait_cyc(5);
    chk_pulses("conc_x", vx_t, vx_v, t0 + 7, 4, 5, 3);
    chk_pulses("conc_y", vy_t, vy_v, t0 + 104, 101, 3, 100);

    // Stall after a 9 measurement, recovery without valid, then a fresh measurement
    idle();
    t0 = cyc_n;
    gen(1'b0, 10, 2);
    wait_cyc(50);
    chk("stall_set", t_stalled_x, 1);
    chk("stall_rise_time", t_stall_rise, t0 + 64);
    t1 = cyc_n;
    step_x = ~step_x;
    wait_cyc(2);
    chk("stall_hold", t_stalled_x, 1);
    wait_cyc(1);
    chk("stall_clear", t_stalled_x, 0);
    chk("stall_clear_no_valid", tx_t.size(), 1);
    wait_cyc(5);
    step_x = ~step_x;
    wait_cyc(6);
    chk("stall_count", tx_t.size(), 2);
    chk("stall_m1_time", qat(tx_t, 0), t0 + 13);
    chk("stall_m1_value", qat(tx_v, 0), 9);
    chk("stall_m2_time", qat(tx_t, 1), t1 + 11);
    chk("stall_m2_value", qat(tx_v, 1), 7);

    // Edge on the very cycle count reaches TIMEOUT: reported, no stall
    idle();
    t0 = cyc_n;
    gen(1'b0, 51, 3);
    chk_pulses("tmo_edge", tx_t, tx_v, t0 + 54, 51, 2, 50);
    chk("tmo_edge_no_stall_rise", t_stall_rise, -1);
    chk("tmo_edge_stalled", t_stalled_x, 0);

    // Enable dropped mid-interval: value held, first edge afterwards silent
    idle();
    t0 = cyc_n;
    gen(1'b0, 6, 3);
    enable = 1'b0;
    wait_cyc(2);
    step_x = ~step_x;
    wait_cyc(8);
    chk("en_hold_value", speed_x_meas, 5);
    chk("en_valid_low", valid_x, 0);
    chk("en_no_pulse", vx_t.size(), 2);
    enable = 1'b1;
    wait_cyc(2);
    t1 = cyc_n;
    gen(1'b0, 7, 3);
    chk("en_count", vx_t.size(), 4);
    chk("en_pre_value", qat(vx_v, 1), 5);
    chk("en_post1_time", qat(vx_t, 2), t1 + 10);
    chk("en_post1_value", qat(vx_v, 2), 6);
    chk("en_post2_time", qat(vx_t, 3), t1 + 17);
    chk("en_post2_value", qat(vx_v, 3), 6);

    // Reset mid-interval: everything zero, one suppressed edge afterwards
    idle();
    t0 = cyc_n;
    gen(1'b0, 6, 2);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    chk("mrst_speed_x", speed_x_meas, 0);
    chk("mrst_valid_x", valid_x, 0);
    chk("mrst_stalled_x", stalled_x, 0);
    chk("mrst_t_speed_x", t_speed_x, 0);
    rst = 1'b0;
    wait_cyc(1);
    t1 = cyc_n;
    gen(1'b0, 8, 3);
    chk("mrst_count", vx_t.size(), 3);
    chk("mrst_pre_value", qat(vx_v, 0), 5);
    chk("mrst_post1_time", qat(vx_t, 1), t1 + 11);
    chk("mrst_post1_value", qat(vx_v, 1), 7);
    chk("mrst_post2_time", qat(vx_t, 2), t1 + 19);

    // Toggle every cycle measures as 0 with back-to-back pulses
    idle();
    t0 = cyc_n;
    gen(1'b0, 1, 6);
    wait_cyc(6);
    chk_pulses("s0_x", vx_t, vx_v, t0 + 4, 1, 5, 0);

    chk("meas_change_without_valid", bad_upd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
